// File: rtl/uart_rx_core.sv
// uart_rx_core: 8O1 asynchronous serial receiver.
// The raw line is synchronized into clk. Each bit is then sampled once at
// mid-bit. A good frame produces one rdata_vld pulse with the byte on rdata.
// Frames with a parity or stop-bit error are dropped silently.
module uart_rx_core #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int CLKS_PER_BIT = (CLK_FREQ + BAUD_RATE / 2) / BAUD_RATE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       rdata_vld,
    output logic [7:0] rdata
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic             perr;
    logic             cnt_clr;
    logic             shift_en;
    logic             par_en;
    logic             load_en;

    // Odd parity check: the result is 1 when data plus parity holds an even number of ones.
    function automatic logic odd_parity_err(input logic [7:0] d, input logic p);
        return (^d) ^ p ^ 1'b1;
    endfunction

    // Two-flop synchronizer for the asynchronous line. It resets to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle control strobes for the datapath.
    always_comb begin
        state_d  = state_q;
        cnt_clr  = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        load_en  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr = 1'b1;
                // A comparison against X is not true, so an unknown line stays idle.
                if (rx_s == 1'b0) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the start bit at mid-bit. Clearing the counter here
                // places every later sample at mid-bit as well.
                if (cnt == CNT_HALF) begin
                    cnt_clr = 1'b1;
                    state_d = (rx_s == 1'b0) ? DATA : IDLE;
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_clr  = 1'b1;
                    shift_en = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_clr = 1'b1;
                    par_en  = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                // Leave right after the stop sample, so the receiver is ready
                // half a bit early for a back-to-back frame.
                if (cnt == CNT_LAST) begin
                    cnt_clr = 1'b1;
                    load_en = rx_s && !perr;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bit-period counter and data bit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
        end else begin
            if (cnt_clr) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (state_q != DATA) begin
                bit_idx <= 3'd0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 3'd1;
            end
        end
    end

    // Capture the data bits LSB first, then record the parity verdict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift <= 8'h00;
            perr  <= 1'b0;
        end else begin
            if (shift_en) begin
                shift[bit_idx] <= rx_s;
            end
            if (par_en) begin
                perr <= odd_parity_err(shift, rx_s);
            end
        end
    end

    // Output register. rdata holds the last good byte, and rdata_vld is a one-clock pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_vld <= 1'b0;
            rdata     <= 8'h00;
        end else begin
            rdata_vld <= load_en;
            if (load_en) begin
                rdata <= shift;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core: directed frames into uart_rx_core, checked against hand-computed bytes.
// The receiver runs at 16 clocks per bit to keep the run short.
module tb_uart_rx_core;

    localparam int BIT  = 16;
    localparam int BAUD = 6_250_000;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic       rdata_vld;
    logic [7:0] rdata;

    int         nchecks = 0;
    int         nerr    = 0;
    int         cyc     = 0;
    int         run     = 0;
    int         t0;
    logic [7:0] got[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];

    uart_rx_core #(
        .CLK_FREQ (100_000_000),
        .BAUD_RATE(BAUD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rdata_vld(rdata_vld),
        .rdata    (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free-running cycle counter, used to time the pulses.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchecks++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Record every rdata_vld pulse and check that each one is a single clock wide.
    always @(negedge clk) begin
        if (rdata_vld) begin
            if (run == 0) begin
                got.push_back(rdata);
                got_cyc.push_back(cyc);
            end
            run++;
        end else begin
            if (run != 0) check("vld_width", run, 1);
            run = 0;
        end
    end

    // Compare the recorded pulses with exp_q, then clear both queues.
    task automatic check_rx(input string tag);
        check({tag, "_count"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got[i], exp_q[i]);
        got.delete();
        got_cyc.delete();
        exp_q.delete();
    endtask

    // Send one frame: start bit, d[0..7], parity (optionally inverted), stop bit.
    // The line then stays high to make up nstop bit times in total.
    task automatic send(input logic [7:0] d, input bit pflip, input bit stopv, input int nstop);
        logic [10:0] bits;
        bits = {stopv, (~^d) ^ pflip, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            uart_rx = bits[i];
            repeat (BIT) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat ((nstop - 1) * BIT) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_vld", rdata_vld, 0);
        check("rst_rdata", rdata, 8'h00);
        rst = 1'b0;
        repeat (200) @(negedge clk);

        // Five good frames with 3 stop-bit times each, plus the fixed start-to-pulse latency.
        t0 = cyc;
        send(8'h12, 0, 1, 3);
        send(8'hFF, 0, 1, 3);
        send(8'h00, 0, 1, 3);
        send(8'hAA, 0, 1, 3);
        send(8'h55, 0, 1, 3);
        repeat (2 * BIT) @(negedge clk);
        check("latency", (got_cyc.size() > 0) ? got_cyc[0] - t0 : -1, 2 + 10 * BIT + BIT / 2 + 1);
        exp_q = '{8'h12, 8'hFF, 8'h00, 8'hAA, 8'h55};
        check_rx("basic");
        check("hold_55", rdata, 8'h55);

        // Parity error, then a good frame.
        send(8'hA5, 1, 1, 3);
        repeat (2 * BIT) @(negedge clk);
        check_rx("perr");
        check("perr_hold", rdata, 8'h55);
        send(8'h3C, 0, 1, 3);
        repeat (2 * BIT) @(negedge clk);
        exp_q = '{8'h3C};
        check_rx("after_perr");

        // Framing error (stop bit driven 0), then a good frame.
        send(8'h81, 0, 0, 3);
        repeat (4 * BIT) @(negedge clk);
        check_rx("ferr");
        check("ferr_hold", rdata, 8'h3C);
        send(8'h7E, 0, 1, 3);
        repeat (2 * BIT) @(negedge clk);
        exp_q = '{8'h7E};
        check_rx("after_ferr");

        // Short low glitch on the idle line, then a good frame.
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check_rx("glitch");
        send(8'h5A, 0, 1, 3);
        repeat (2 * BIT) @(negedge clk);
        exp_q = '{8'h5A};
        check_rx("after_glitch");

        // Reset pulse in the middle of data bit 4 of 0xC3.
        fork
            send(8'hC3, 0, 1, 3);
            begin
                repeat (5 * BIT + BIT / 2) @(negedge clk);
                rst = 1'b1;
                repeat (50) @(negedge clk);
                check("midrst_vld", rdata_vld, 0);
                check("midrst_rdata", rdata, 8'h00);
                repeat (50) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (2 * BIT) @(negedge clk);
        check_rx("rst_abort");
        send(8'h19, 0, 1, 3);
        repeat (2 * BIT) @(negedge clk);
        exp_q = '{8'h19};
        check_rx("after_rst");

        // Back-to-back frames with a single stop bit.
        send(8'h01, 0, 1, 1);
        send(8'h80, 0, 1, 1);
        repeat (3 * BIT) @(negedge clk);
        check("b2b_spacing", (got_cyc.size() > 1) ? got_cyc[1] - got_cyc[0] : -1, 11 * BIT);
        exp_q = '{8'h01, 8'h80};
        check_rx("b2b");

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
